// File: rtl/crc5_ddr_engine_pkg.sv
// Purpose : shared HDR-DDR CRC-5 definitions (state enum, seed/poly, bit-step function).
// Latency : n/a (types and a pure combinational helper).
// Backpressure: n/a.
// Contents: crc_state_e, crc5_t, rx_byte_t, CRC5_SEED, CRC5_POLY, crc5_step().
package crc5_ddr_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } crc_state_e;

  typedef logic [4:0] crc5_t;
  typedef logic [7:0] rx_byte_t;

  localparam crc5_t CRC5_SEED = 5'h1F;
  localparam crc5_t CRC5_POLY = 5'h05;  // x^2 + 1 taps; x^5 is implied by the shift-out

  // One MSB-first step of the I3C CRC-5. Shared with the TX-side generator.
  function automatic crc5_t crc5_step(input crc5_t crc, input logic din,
                                      input crc5_t poly = CRC5_POLY);
    logic fb;
    fb = crc[4] ^ din;
    return {crc[3:0], 1'b0} ^ (fb ? poly : 5'h00);
  endfunction

endpackage

// File: rtl/crc5_ddr_engine_if.sv
// Purpose : RX-stage <-> CRC-5 engine signal bundle.
// Latency : n/a (wires only).
// Backpressure: none; strobes beyond FIFO capacity are dropped and flagged by the engine.
// Ports   : i_rx_crc_en, i_rx_crc_data_valid, i_rx_data[7:0], i_rx_crc_last_byte (RX -> engine);
//           o_rx_crc_value[4:0], o_rx_crc_valid, o_crc_busy, o_crc_overflow (engine -> RX).
interface crc5_ddr_engine_if;
  import crc5_ddr_engine_pkg::*;

  logic     i_rx_crc_en;
  logic     i_rx_crc_data_valid;
  rx_byte_t i_rx_data;
  logic     i_rx_crc_last_byte;
  crc5_t    o_rx_crc_value;
  logic     o_rx_crc_valid;
  logic     o_crc_busy;
  logic     o_crc_overflow;

  // Engine side.
  modport slave (
    input  i_rx_crc_en, i_rx_crc_data_valid, i_rx_data, i_rx_crc_last_byte,
    output o_rx_crc_value, o_rx_crc_valid, o_crc_busy, o_crc_overflow
  );

  // RX deserializer side.
  modport master (
    output i_rx_crc_en, i_rx_crc_data_valid, i_rx_data, i_rx_crc_last_byte,
    input  o_rx_crc_value, o_rx_crc_valid, o_crc_busy, o_crc_overflow
  );

endinterface

// File: rtl/crc5_ddr_engine_fifo.sv
// Purpose : small synchronous byte FIFO (head is visible combinationally) with sync flush.
// Latency : push visible at the head one cycle later.
// Backpressure: caller must not push when full unless popping in the same cycle.
// Ports   : i_clk, i_rst_n, i_flush, i_push, i_push_dat, i_pop, o_head_dat, o_full, o_empty.
module ddr_byte_fifo #(
  parameter int DEPTH = 2,   // power of two, >= 2
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers/count.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_full     = (r_count == CNT_FULL);
  assign o_empty    = (r_count == '0);

endmodule

// File: rtl/crc5_ddr_engine.sv
// Purpose : HDR-DDR RX CRC-5 engine: queues strobed bytes, folds them in bit-serially, reports on finalize.
// Latency : strobe at T with engine idle and finalize pending -> o_rx_crc_valid high from T+11; 9 cycles/byte.
// Backpressure: none upstream; a strobe into a full queue (no same-cycle retire) is dropped, o_crc_overflow sticks.
// Ports   : i_sys_clk, i_sys_rst (async, active-low), io_bus (slave modport of crc5_ddr_engine_if).
module crc5_ddr_engine
  import crc5_ddr_engine_pkg::*;
#(
  parameter int    FIFO_DEPTH = 2,
  parameter crc5_t CRC_SEED   = CRC5_SEED,
  parameter crc5_t CRC_POLY   = CRC5_POLY
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  crc5_ddr_engine_if.slave  io_bus
);

  logic       w_en, w_stb, w_last, w_flush;
  logic       w_fifo_full, w_fifo_empty, w_push, w_pop;
  rx_byte_t   w_fifo_head;

  crc_state_e r_state, w_state_nxt;
  crc5_t      r_crc, w_crc_nxt;
  crc5_t      r_crc_value, w_crc_value_nxt;
  rx_byte_t   r_shift, w_shift_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic       r_pending, w_pending_nxt;
  logic       r_crc_valid, w_crc_valid_nxt;
  logic       r_overflow, w_overflow_nxt;

  assign w_en    = io_bus.i_rx_crc_en;
  assign w_flush = ~w_en;
  assign w_stb   = io_bus.i_rx_crc_data_valid & w_en;
  assign w_last  = io_bus.i_rx_crc_last_byte & w_en;

  // The byte being shifted stays in the queue until its last bit is folded in,
  // so the queue slot is only released (popped) on the final SHIFT cycle. This is
  // what limits a depth-2 queue to two back-to-back strobes.
  assign w_pop  = w_en && (r_state == ST_SHIFT) && (r_bit_cnt == 3'd0);
  assign w_push = w_stb && (!w_fifo_full || w_pop);

  ddr_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk      (i_sys_clk),
    .i_rst_n    (i_sys_rst),
    .i_flush    (w_flush),
    .i_push     (w_push),
    .i_push_dat (io_bus.i_rx_data),
    .i_pop      (w_pop),
    .o_head_dat (w_fifo_head),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  // State register.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (!w_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_fifo_empty)  w_state_nxt = ST_SHIFT;
          else if (r_pending) w_state_nxt = ST_DONE;
        end
        ST_SHIFT: if (r_bit_cnt == 3'd0) w_state_nxt = ST_IDLE;
        ST_DONE:  if (w_stb) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath / output next values.
  always_comb begin
    w_crc_nxt       = r_crc;
    w_shift_nxt     = r_shift;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_pending_nxt   = r_pending | w_last;
    w_crc_value_nxt = r_crc_value;
    w_crc_valid_nxt = r_crc_valid;
    w_overflow_nxt  = r_overflow | (w_stb && w_fifo_full && !w_pop);

    if (!w_en) begin
      w_crc_nxt       = CRC_SEED;
      w_shift_nxt     = '0;
      w_bit_cnt_nxt   = '0;
      w_pending_nxt   = 1'b0;
      w_crc_value_nxt = '0;
      w_crc_valid_nxt = 1'b0;
      w_overflow_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_fifo_empty) begin
            // Load only; the first CRC step happens in the next cycle.
            w_shift_nxt   = w_fifo_head;
            w_bit_cnt_nxt = 3'd7;
          end else if (r_pending) begin
            // Finalize wins over a same-cycle last_byte (already pending).
            w_crc_value_nxt = r_crc;
            w_crc_valid_nxt = 1'b1;
            w_crc_nxt       = CRC_SEED;
            w_pending_nxt   = 1'b0;
          end
        end
        ST_SHIFT: begin
          w_crc_nxt   = crc5_step(r_crc, r_shift[7], CRC_POLY);
          w_shift_nxt = {r_shift[6:0], 1'b0};
          if (r_bit_cnt != 3'd0) w_bit_cnt_nxt = r_bit_cnt - 3'd1;
        end
        ST_DONE: begin
          if (w_stb) w_crc_valid_nxt = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_crc       <= CRC_SEED;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_pending   <= 1'b0;
      r_crc_value <= '0;
      r_crc_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_crc       <= w_crc_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_pending   <= w_pending_nxt;
      r_crc_value <= w_crc_value_nxt;
      r_crc_valid <= w_crc_valid_nxt;
      r_overflow  <= w_overflow_nxt;
    end
  end

  assign io_bus.o_rx_crc_value = r_crc_value;
  assign io_bus.o_rx_crc_valid = r_crc_valid;
  assign io_bus.o_crc_overflow = r_overflow;
  // Built only from registered state, so no input reaches this output combinationally.
  assign io_bus.o_crc_busy     = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_crc5_ddr_engine.sv
// Purpose : self-checking bench for crc5_ddr_engine (directed vectors + random frames).
// Latency : checks the 11- and 20-cycle result latencies on the directed frames.
// Backpressure: exercises the two-deep queue limit and the sticky overflow flag.
module tb_crc5_ddr_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  crc5_ddr_engine_if bus();

  crc5_ddr_engine #(.FIFO_DEPTH(2)) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst_n),
    .io_bus    (bus)
  );

  typedef struct {
    logic [4:0] crc;
    int         due;   // cycle the result must appear, -1 = not timed
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic prev_vld = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // CRC as the remainder of (seed * x^n + M(x) * x^5) mod (x^5 + x^2 + 1), by long division.
  function automatic logic [4:0] model_crc(input logic [7:0] msg[$]);
    logic       b[$];
    int         n;
    logic [5:0] g;
    logic [4:0] seed;
    logic [4:0] r;
    g    = 6'b100101;
    seed = 5'h1F;
    foreach (msg[k]) for (int i = 7; i >= 0; i--) b.push_back(msg[k][i]);
    n = b.size();
    repeat (5) b.push_back(1'b0);
    for (int i = 0; i < 5; i++) b[i] = b[i] ^ seed[4-i];
    for (int i = 0; i < n; i++)
      if (b[i]) for (int j = 0; j < 6; j++) b[i+j] = b[i+j] ^ g[5-j];
    for (int i = 0; i < 5; i++) r[4-i] = b[n+i];
    return r;
  endfunction

  // Monitor: every rising edge of o_rx_crc_valid consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && bus.o_rx_crc_valid && !prev_vld) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: value 0x%0h appeared with no frame outstanding", bus.o_rx_crc_value);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("crc_value", bus.o_rx_crc_value, e.crc);
        if (e.due >= 0) check("valid_latency_cycle", cyc, e.due);
      end
    end
    prev_vld = bus.o_rx_crc_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic expect_crc(input logic [4:0] crc, input int due);
    exp_t e;
    e.crc = crc;
    e.due = due;
    sbq.push_back(e);
  endtask

  task automatic strobe(input logic [7:0] d, input logic last);
    bus.i_rx_crc_data_valid = 1'b1;
    bus.i_rx_data           = d;
    bus.i_rx_crc_last_byte  = last;
    tick();
    bus.i_rx_crc_data_valid = 1'b0;
    bus.i_rx_crc_last_byte  = 1'b0;
  endtask

  task automatic pulse_last();
    bus.i_rx_crc_last_byte = 1'b1;
    tick();
    bus.i_rx_crc_last_byte = 1'b0;
  endtask

  task automatic en_drop();
    bus.i_rx_crc_en = 1'b0;
    tick();
    bus.i_rx_crc_en = 1'b1;
  endtask

  task automatic drain(input int budget, input string name);
    int k;
    k = 0;
    while (sbq.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: result not seen within %0d cycles, %0d outstanding", name, budget, sbq.size());
      sbq.delete();
    end
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_value"},    bus.o_rx_crc_value, 0);
    check({tag, "_valid"},    bus.o_rx_crc_valid, 0);
    check({tag, "_busy"},     bus.o_crc_busy, 0);
    check({tag, "_overflow"}, bus.o_crc_overflow, 0);
  endtask

  // Hard stop if something wedges the stimulus itself.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    int t;
    logic [7:0] msg[$];
    int len;
    int g;
    bit pair_prev;
    bit last_with;

    bus.i_rx_crc_en         = 1'b0;
    bus.i_rx_crc_data_valid = 1'b0;
    bus.i_rx_data           = 8'h00;
    bus.i_rx_crc_last_byte  = 1'b0;
    rst_n = 1'b0;
    idle(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    bus.i_rx_crc_en = 1'b1;
    tick();

    // Single 0x00 with last_byte on the strobe.
    t = cyc;
    expect_crc(5'h0F, t + 11);
    strobe(8'h00, 1'b1);
    check("busy_rise", bus.o_crc_busy, 1);
    idle(9);
    check("busy_fall_at_idle", bus.o_crc_busy, 0);
    drain(40, "single_00");

    // Single 0xFF, last_byte afterwards.
    expect_crc(5'h1B, -1);
    strobe(8'hFF, 1'b0);
    idle(2);
    pulse_last();
    drain(40, "single_ff");

    // Two back-to-back strobes, last at T+2.
    t = cyc;
    expect_crc(5'h01, t + 20);
    strobe(8'h00, 1'b0);
    strobe(8'h00, 1'b0);
    pulse_last();
    check("pair_no_overflow", bus.o_crc_overflow, 0);
    drain(60, "pair_00");

    // Three back-to-back strobes: the third is dropped.
    t = cyc;
    expect_crc(5'h01, t + 20);
    strobe(8'h00, 1'b0);
    strobe(8'h00, 1'b0);
    strobe(8'h00, 1'b1);
    check("triple_overflow", bus.o_crc_overflow, 1);
    drain(60, "triple_00");
    check("overflow_sticky", bus.o_crc_overflow, 1);

    // Enable dropped while shifting bit 4, then a clean frame.
    strobe(8'h00, 1'b0);
    idle(4);
    bus.i_rx_crc_en = 1'b0;
    tick();
    check_all_zero("en_flush");
    bus.i_rx_crc_en = 1'b1;
    t = cyc;
    expect_crc(5'h0F, t + 11);
    strobe(8'h00, 1'b1);
    drain(40, "after_flush");

    // Finalize with no bytes.
    en_drop();
    t = cyc;
    expect_crc(5'h1F, t + 2);
    pulse_last();
    drain(20, "empty_frame");

    // Random frames checked against the division model.
    for (int f = 0; f < 24; f++) begin
      msg.delete();
      len = $urandom_range(0, 4);
      if (len == 0 || $urandom_range(0, 3) == 0) en_drop();
      for (int k = 0; k < len; k++) msg.push_back(8'($urandom()));
      last_with = (len > 0) && ($urandom_range(0, 1) == 1);
      expect_crc(model_crc(msg), -1);
      pair_prev = 1'b0;
      for (int k = 0; k < len; k++) begin
        if (k > 0) begin
          if (pair_prev) begin
            g = $urandom_range(18, 22);
            pair_prev = 1'b0;
          end else if ($urandom_range(0, 2) == 0) begin
            g = 1;
            pair_prev = 1'b1;
          end else begin
            g = $urandom_range(10, 14);
          end
          idle(g - 1);
        end
        strobe(msg[k], last_with && (k == len - 1));
      end
      if (!last_with) begin
        idle($urandom_range(0, 20));
        pulse_last();
      end
      drain(300, "rand_frame");
    end

    // Async reset mid-SHIFT.
    strobe(8'hA5, 1'b0);
    idle(3);
    check("busy_mid_shift", bus.o_crc_busy, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("areset_shift");
    tick();
    rst_n = 1'b1;
    tick();

    // Async reset while holding a result in DONE.
    msg.delete();
    msg.push_back(8'h3C);
    expect_crc(model_crc(msg), -1);
    strobe(8'h3C, 1'b1);
    drain(40, "pre_done_reset");
    #2 rst_n = 1'b0;
    #1 check_all_zero("areset_done");
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
